// File: rtl/bank_select_encoder.sv
// bank_select_encoder
//
// Round-robin arbiter for a 4-bank memory. It picks one requesting bank and
// drives a registered chip select, a binary bank index and a one-hot grant.
// Each grant ends with a one-cycle RELEASE that acts as the bus turnaround.
//
// Optional feature (macro BANK_SELECT_ENCODER_TIMEOUT_EN):
//   When the macro is defined, an 8-bit hold counter limits a grant to
//   HOLD_MAX consecutive cycles. When it is undefined, a grant ends only on
//   Done or when the owner drops its request.
//
// Parameters:
//   HOLD_MAX  maximum consecutive GRANT cycles per grant (1..255)
//
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   synchronous active-low reset
//   Req    in   [3:0] level-sensitive per-bank requests
//   Done   in   current owner ends its access
//   CS     out  registered chip select
//   BSOut  out  [1:0] registered bank index, valid while CS=1
//   Grant  out  [3:0] registered one-hot grant (0 when CS=0)
//   Busy   out  registered, 1 in GRANT and RELEASE

module bank_select_encoder #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] Req,
  input  logic       Done,
  output logic       CS,
  output logic [1:0] BSOut,
  output logic [3:0] Grant,
  output logic       Busy
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic       exit_grant;

  // Elaboration-time guard on the parameter range.
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("bank_select_encoder: HOLD_MAX out of range 1..255");
  end

  // Round-robin search: first set request going upward from ptr+1, wrapping.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && Req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef BANK_SELECT_ENCODER_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;

  assign exit_grant = Done || !Req[BSOut] || (hold_cnt == HoldLast);
`else
  assign exit_grant = Done || !Req[BSOut];
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= StIdle;
      CS    <= 1'b0;
      BSOut <= 2'b00;
      Grant <= 4'b0000;
      Busy  <= 1'b0;
      ptr   <= 2'd3;  // bank 0 gets first priority after reset
`ifdef BANK_SELECT_ENCODER_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (|Req) begin
            state <= StGrant;
            CS    <= 1'b1;
            BSOut <= winner;
            Grant <= 4'b0001 << winner;
            Busy  <= 1'b1;
            ptr   <= winner;
`ifdef BANK_SELECT_ENCODER_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end else begin
            CS    <= 1'b0;
            BSOut <= 2'b00;
            Grant <= 4'b0000;
            Busy  <= 1'b0;
          end
        end
        StGrant: begin
          // Other banks are ignored here: no preemption.
          if (exit_grant) begin
            state <= StRelease;
            CS    <= 1'b0;
            Grant <= 4'b0000;
            // BSOut holds its value through the turnaround cycle.
          end
`ifdef BANK_SELECT_ENCODER_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        StRelease: begin
          state <= StIdle;
          BSOut <= 2'b00;
          Busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          CS    <= 1'b0;
          BSOut <= 2'b00;
          Grant <= 4'b0000;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
